bavul_gise_hakemi: RTL and testbench

//  Round-robin arbiter/sequencer sharing one bavul fee unit between GISE_SAYISI check-in desks.

---
 rtl/bavul_gise_hakemi.sv | 193 +++++++++++++++++++
 tb/tb_bavul_gise_hakemi.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bavul_gise_hakemi.sv
// bavul_gise_hakemi: round-robin arbiter that lets several check-in desks share
// one bavul fee unit, with a done timeout and a saturating revenue total.
//
// Ports
//   saat           clock, rising edge
//   reset          asynchronous active-low reset
//   istek          per-desk request, held until that desk sees its kabul
//   agirlik_gir    desk i weight at [6i+5:6i], valid while istek[i]
//   toplam_sil     synchronous clear of toplam
//   kabul          one-hot grant pulse (one cycle, GONDER)
//   yanit_gecerli  one-hot response pulse (one cycle, YANIT)
//   yanit_ucret    fee for the responding desk, 0 outside YANIT
//   hata           timeout flag, 0 outside YANIT
//   mesgul         high in every state except BOS
//   b_basla        start pulse to the fee unit
//   b_agirlik      weight to the fee unit, stable GONDER..YANIT
//   b_ucret        fee from the fee unit, sampled only with b_bitti
//   b_bitti        fee unit done, ignored outside GONDER/BEKLE
//   toplam         saturating sum of successful fees
module bavul_gise_hakemi #(
    parameter int GISE_SAYISI     = 4,
    parameter int ZAMAN_ASIMI     = 16,
    parameter int TOPLAM_GENISLIK = 16
) (
    input  logic                         saat,
    input  logic                         reset,
    input  logic [GISE_SAYISI-1:0]       istek,
    input  logic [6*GISE_SAYISI-1:0]     agirlik_gir,
    input  logic                         toplam_sil,
    output logic [GISE_SAYISI-1:0]       kabul,
    output logic [GISE_SAYISI-1:0]       yanit_gecerli,
    output logic [7:0]                   yanit_ucret,
    output logic                         hata,
    output logic                         mesgul,
    output logic                         b_basla,
    output logic [5:0]                   b_agirlik,
    input  logic [7:0]                   b_ucret,
    input  logic                         b_bitti,
    output logic [TOPLAM_GENISLIK-1:0]   toplam
);

    localparam int IW = (GISE_SAYISI > 1) ? $clog2(GISE_SAYISI) : 1;
    localparam int SW = (ZAMAN_ASIMI > 1) ? $clog2(ZAMAN_ASIMI) : 1;
    localparam int TW = TOPLAM_GENISLIK;

    typedef enum logic [1:0] {
        BOS    = 2'd0,
        GONDER = 2'd1,
        BEKLE  = 2'd2,
        YANIT  = 2'd3
    } durum_t;

    durum_t          durum_q, durum_d;
    logic [IW-1:0]   sec_q, sec_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [5:0]      agirlik_q, agirlik_d;
    logic [7:0]      ucret_q, ucret_d;
    logic            hata_q, hata_d;
    logic [SW-1:0]   sayac_q, sayac_d;
    logic [TW-1:0]   toplam_q, toplam_d;

    logic [IW-1:0]   aday;
    logic [IW-1:0]   bak;
    logic            bulundu;
    logic [5:0]      aday_agirlik;
    logic [GISE_SAYISI-1:0] sec_onehot;
    logic            ekle;
    logic [TW:0]     toplam_toplami;

    // Round-robin search: first requesting desk after the last one served,
    // wrapping around, so the last winner has the lowest priority.
    always_comb begin
        bulundu = 1'b0;
        aday    = ptr_q;
        bak     = ptr_q;
        for (int k = 1; k <= GISE_SAYISI; k++) begin
            bak = IW'((int'(ptr_q) + k) % GISE_SAYISI);
            if (!bulundu && istek[bak]) begin
                bulundu = 1'b1;
                aday    = bak;
            end
        end
    end

    always_comb begin
        aday_agirlik = 6'd0;
        for (int i = 0; i < GISE_SAYISI; i++) begin
            if (aday == IW'(i)) begin
                aday_agirlik = agirlik_gir[6*i +: 6];
            end
        end
    end

    always_comb begin
        durum_d   = durum_q;
        sec_d     = sec_q;
        ptr_d     = ptr_q;
        agirlik_d = agirlik_q;
        ucret_d   = ucret_q;
        hata_d    = hata_q;
        sayac_d   = sayac_q;
        unique case (durum_q)
            BOS: begin
                if (bulundu) begin
                    sec_d     = aday;
                    ptr_d     = aday;
                    agirlik_d = aday_agirlik;
                    ucret_d   = 8'd0;
                    hata_d    = 1'b0;
                    durum_d   = GONDER;
                end
            end
            GONDER: begin
                if (b_bitti) begin
                    // Zero-wait fee unit: done in the same cycle as start.
                    ucret_d = b_ucret;
                    hata_d  = 1'b0;
                    durum_d = YANIT;
                end else begin
                    sayac_d = '0;
                    durum_d = BEKLE;
                end
            end
            BEKLE: begin
                if (b_bitti) begin
                    ucret_d = b_ucret;
                    hata_d  = 1'b0;
                    durum_d = YANIT;
                end else if (sayac_q == SW'(ZAMAN_ASIMI - 1)) begin
                    ucret_d = 8'd0;
                    hata_d  = 1'b1;
                    durum_d = YANIT;
                end else begin
                    sayac_d = sayac_q + 1'b1;
                end
            end
            YANIT: begin
                durum_d = BOS;
            end
            default: begin
                durum_d = BOS;
            end
        endcase
    end

    // YANIT always returns to BOS, so "leaving YANIT" is simply "in YANIT".
    assign ekle = (durum_q == YANIT) && !hata_q;
    assign toplam_toplami = {1'b0, toplam_q}
                          + {{(TW - 7){1'b0}}, ucret_q};

    always_comb begin
        toplam_d = toplam_q;
        if (toplam_sil) begin
            // A clear coinciding with an add keeps only the new fee.
            toplam_d = ekle ? TW'(ucret_q) : '0;
        end else if (ekle) begin
            toplam_d = toplam_toplami[TW] ? '1 : toplam_toplami[TW-1:0];
        end
    end

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            durum_q   <= BOS;
            sec_q     <= '0;
            ptr_q     <= IW'(GISE_SAYISI - 1);
            agirlik_q <= 6'd0;
            ucret_q   <= 8'd0;
            hata_q    <= 1'b0;
            sayac_q   <= '0;
            toplam_q  <= '0;
        end else begin
            durum_q   <= durum_d;
            sec_q     <= sec_d;
            ptr_q     <= ptr_d;
            agirlik_q <= agirlik_d;
            ucret_q   <= ucret_d;
            hata_q    <= hata_d;
            sayac_q   <= sayac_d;
            toplam_q  <= toplam_d;
        end
    end

    assign sec_onehot    = {{(GISE_SAYISI - 1){1'b0}}, 1'b1} << sec_q;
    assign kabul         = (durum_q == GONDER) ? sec_onehot : '0;
    assign yanit_gecerli = (durum_q == YANIT) ? sec_onehot : '0;
    assign yanit_ucret   = (durum_q == YANIT) ? ucret_q : 8'd0;
    assign hata          = (durum_q == YANIT) && hata_q;
    assign mesgul        = (durum_q != BOS);
    assign b_basla       = (durum_q == GONDER);
    assign b_agirlik     = agirlik_q;
    assign toplam        = toplam_q;

endmodule

// File: tb/tb_bavul_gise_hakemi.sv
// Directed bench for bavul_gise_hakemi with a small fee-unit model that can
// answer at once, after five cycles, or never.
module tb_bavul_gise_hakemi;

    logic        saat = 1'b0;
    logic        reset;
    logic [3:0]  istek;
    logic [23:0] agirlik_gir;
    logic        toplam_sil;
    logic [3:0]  kabul;
    logic [3:0]  yanit_gecerli;
    logic [7:0]  yanit_ucret;
    logic        hata;
    logic        mesgul;
    logic        b_basla;
    logic [5:0]  b_agirlik;
    logic [7:0]  b_ucret;
    logic        b_bitti;
    logic [15:0] toplam;

    int          n_assert = 0;
    int          n_fail   = 0;

    // fee unit model: mode 0 zero-wait, 1 done 5 cycles after start, 2 never
    int          mode = 0;
    logic        fee_w = 1'b0;
    logic [7:0]  fee_sabit = 8'd0;
    int          cnt = 0;

    bavul_gise_hakemi #(
        .GISE_SAYISI(4),
        .ZAMAN_ASIMI(16),
        .TOPLAM_GENISLIK(16)
    ) dut (
        .saat(saat),
        .reset(reset),
        .istek(istek),
        .agirlik_gir(agirlik_gir),
        .toplam_sil(toplam_sil),
        .kabul(kabul),
        .yanit_gecerli(yanit_gecerli),
        .yanit_ucret(yanit_ucret),
        .hata(hata),
        .mesgul(mesgul),
        .b_basla(b_basla),
        .b_agirlik(b_agirlik),
        .b_ucret(b_ucret),
        .b_bitti(b_bitti),
        .toplam(toplam)
    );

    always #5 saat = ~saat;

    always @(posedge saat) begin
        if (b_basla) cnt <= 1;
        else if (cnt != 0 && cnt < 7) cnt <= cnt + 1;
    end

    always_comb begin
        b_bitti = 1'b0;
        if (mode == 0) b_bitti = b_basla;
        else if (mode == 1) b_bitti = (cnt == 5);
        b_ucret = fee_w ? 8'(b_agirlik * 3) : fee_sabit;
    end

    task automatic tick();
        @(posedge saat);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_kabul();
        int n = 0;
        while (kabul == 4'd0 && n < 40) begin
            tick();
            n++;
        end
        chk("kabul_seen", {31'd0, |kabul}, 32'd1);
    endtask

    task automatic wait_yanit();
        int n = 0;
        while (yanit_gecerli == 4'd0 && n < 40) begin
            tick();
            n++;
        end
        chk("yanit_seen", {31'd0, |yanit_gecerli}, 32'd1);
    endtask

    task automatic serve(input int desk, input int fee, input int hh);
        wait_kabul();
        chk("kabul_desk", kabul, 32'd1 << desk);
        istek[desk] = 1'b0;
        wait_yanit();
        chk("yanit_desk", yanit_gecerli, 32'd1 << desk);
        chk("yanit_ucret", yanit_ucret, fee);
        chk("yanit_hata", hata, hh);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic last_bitti;
        reset       = 1'b1;
        istek       = 4'd0;
        agirlik_gir = 24'd0;
        toplam_sil  = 1'b0;
        #1 reset = 1'b0;
        tick();
        tick();
        chk("rst_kabul", kabul, 0);
        chk("rst_yanit", yanit_gecerli, 0);
        chk("rst_mesgul", mesgul, 0);
        chk("rst_basla", b_basla, 0);
        chk("rst_toplam", toplam, 0);
        chk("rst_agirlik", b_agirlik, 0);
        chk("rst_hata", hata, 0);
        chk("rst_ucret", yanit_ucret, 0);
        reset = 1'b1;

        // 1: single zero-wait request from desk 1
        mode = 0;
        fee_sabit = 8'd45;
        agirlik_gir = {6'd0, 6'd0, 6'd14, 6'd0};
        istek = 4'b0010;
        tick();
        chk("t1_kabul", kabul, 4'b0010);
        chk("t1_basla", b_basla, 1);
        chk("t1_agirlik", b_agirlik, 14);
        chk("t1_mesgul", mesgul, 1);
        chk("t1_noyanit", yanit_gecerli, 0);
        istek = 4'b0000;
        tick();
        chk("t1_kabul_off", kabul, 0);
        chk("t1_basla_off", b_basla, 0);
        chk("t1_yanit", yanit_gecerli, 4'b0010);
        chk("t1_ucret", yanit_ucret, 45);
        chk("t1_hata", hata, 0);
        chk("t1_agirlik2", b_agirlik, 14);
        tick();
        chk("t1_toplam", toplam, 45);
        chk("t1_yanit_off", yanit_gecerli, 0);
        chk("t1_ucret_off", yanit_ucret, 0);
        chk("t1_idle", mesgul, 0);

        // 2: all desks at once, then 0 and 2 again
        do_reset();
        fee_w = 1'b1;
        agirlik_gir = {6'd40, 6'd30, 6'd20, 6'd10};
        istek = 4'b1111;
        serve(0, 30, 0);
        serve(1, 60, 0);
        serve(2, 90, 0);
        serve(3, 120, 0);
        chk("t2_toplam", toplam, 300);
        istek = 4'b0101;
        serve(0, 30, 0);
        serve(2, 90, 0);
        chk("t2_toplam2", toplam, 420);

        // 3: fee unit answers 5 cycles after start
        mode = 1;
        fee_w = 1'b0;
        fee_sabit = 8'd101;
        agirlik_gir = {6'd0, 6'd7, 6'd0, 6'd0};
        istek = 4'b0100;
        wait_kabul();
        chk("t3_kabul", kabul, 4'b0100);
        chk("t3_basla", b_basla, 1);
        chk("t3_agirlik", b_agirlik, 7);
        istek = 4'b0000;
        n = 0;
        last_bitti = 1'b0;
        tick();
        while (yanit_gecerli == 4'd0 && n < 40) begin
            chk("t3_basla_low", b_basla, 0);
            chk("t3_mesgul", mesgul, 1);
            chk("t3_agirlik_hold", b_agirlik, 7);
            last_bitti = b_bitti;
            n++;
            tick();
        end
        chk("t3_wait_cycles", n, 5);
        chk("t3_bitti_prev", last_bitti, 1);
        chk("t3_yanit", yanit_gecerli, 4'b0100);
        chk("t3_ucret", yanit_ucret, 101);
        chk("t3_hata", hata, 0);
        chk("t3_mesgul_y", mesgul, 1);
        tick();
        chk("t3_toplam", toplam, 521);

        // 4: fee unit never answers
        mode = 2;
        agirlik_gir = {6'd5, 6'd0, 6'd0, 6'd0};
        istek = 4'b1000;
        wait_kabul();
        chk("t4_kabul", kabul, 4'b1000);
        istek = 4'b0000;
        n = 0;
        tick();
        while (yanit_gecerli == 4'd0 && n < 40) begin
            n++;
            tick();
        end
        chk("t4_wait_cycles", n, 16);
        chk("t4_yanit", yanit_gecerli, 4'b1000);
        chk("t4_hata", hata, 1);
        chk("t4_ucret", yanit_ucret, 0);
        tick();
        chk("t4_toplam", toplam, 521);
        chk("t4_hata_off", hata, 0);
        chk("t4_idle", mesgul, 0);

        // 5: saturation, then clear with and without an add
        do_reset();
        mode = 0;
        fee_sabit = 8'd198;
        agirlik_gir = {6'd0, 6'd0, 6'd0, 6'd9};
        for (int i = 0; i < 332; i++) begin
            istek = 4'b0001;
            serve(0, 198, 0);
            if (i == 329) chk("t5_toplam_330", toplam, 65340);
            if (i == 330) chk("t5_toplam_331", toplam, 65535);
        end
        chk("t5_toplam_sat", toplam, 65535);
        fee_sabit = 8'd45;
        istek = 4'b0001;
        wait_kabul();
        istek = 4'b0000;
        wait_yanit();
        chk("t5_ucret45", yanit_ucret, 45);
        toplam_sil = 1'b1;
        tick();
        toplam_sil = 1'b0;
        chk("t5_sil_add", toplam, 45);
        toplam_sil = 1'b1;
        tick();
        toplam_sil = 1'b0;
        chk("t5_sil_only", toplam, 0);

        // 6: reset during BEKLE
        mode = 2;
        fee_sabit = 8'd77;
        agirlik_gir = {6'd3, 6'd0, 6'd12, 6'd2};
        istek = 4'b0010;
        wait_kabul();
        chk("t6_kabul", kabul, 4'b0010);
        istek = 4'b0000;
        tick();
        tick();
        chk("t6_busy", mesgul, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_kabul", kabul, 0);
        chk("t6_rst_basla", b_basla, 0);
        chk("t6_rst_mesgul", mesgul, 0);
        chk("t6_rst_yanit", yanit_gecerli, 0);
        chk("t6_rst_agirlik", b_agirlik, 0);
        chk("t6_rst_hata", hata, 0);
        mode = 0;
        istek = 4'b1001;
        tick();
        tick();
        reset = 1'b1;
        chk("t6_rel_yanit", yanit_gecerli, 0);
        tick();
        chk("t6_noyanit", yanit_gecerli, 0);
        chk("t6_first", kabul, 4'b0001);
        serve(0, 77, 0);
        serve(3, 77, 0);
        chk("t6_toplam", toplam, 154);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
